// File: rtl/islam_ihfaz_db_pkg.sv
// Shared constants for the slide-switch debounce stage that feeds the D-latch tile.
package islam_ihfaz_db_pkg;

  localparam int DB_SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF      = 16;
  localparam int EDGE_CNT_W         = 5;

endpackage : islam_ihfaz_db_pkg

// File: rtl/islam_ihfaz_debounce_ch.sv
// One switch channel: synchroniser chain, hold-time counter and accepted level,
// plus a registered strobe that is high for the first cycle the accepted level is 1.
module islam_ihfaz_debounce_ch
  import islam_ihfaz_db_pkg::*;
#(
  parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    // Any cycle where the synchronised level agrees with the accepted one restarts the hold count.
    if (sync_out != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_out;
        rise_d   = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule : islam_ihfaz_debounce_ch

// File: rtl/tt_um_islam_ihfaz_switch_debounce.sv
// Debounced D / E levels for the D-latch tile, with an enable rising-edge pulse.
// Define SWITCH_DEBOUNCE_EDGE_CNT_EN to expose a wrapping 5-bit enable-edge count on uo_out[7:3].
module tt_um_islam_ihfaz_switch_debounce
  import islam_ihfaz_db_pkg::*;
#(
  parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  logic                  d_clean;
  logic                  e_clean;
  logic                  e_rise;
  logic                  unused_d_rise;
  logic [EDGE_CNT_W-1:0] edge_cnt;

  islam_ihfaz_debounce_ch #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_ch_d (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .raw_i    (ui_in[0]),
    .stable_o (d_clean),
    .rise_o   (unused_d_rise)
  );

  islam_ihfaz_debounce_ch #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_ch_e (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .raw_i    (ui_in[1]),
    .stable_o (e_clean),
    .rise_o   (e_rise)
  );

`ifdef SWITCH_DEBOUNCE_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Counts the registered pulse, so the value moves one cycle after e_rise.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (e_rise) edge_cnt_d = edge_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) edge_cnt_q <= '0;
    else        edge_cnt_q <= edge_cnt_d;
  end

  assign edge_cnt = edge_cnt_q;
`else
  assign edge_cnt = '0;
`endif

  assign uo_out  = {edge_cnt, e_rise, e_clean, d_clean};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:2], unused_d_rise};

endmodule : tt_um_islam_ihfaz_switch_debounce
